// File: rtl/ir_packet_encoder.sv
// ir_packet_encoder: emits one modulated IR remote-control packet per request.
// A packet is a start burst, a car-select burst and four command-bit bursts
// (right, left, backward, forward), each burst followed by a carrier-length gap.
// Burst lengths are counted in whole carrier periods.

module ir_packet_encoder #(
  parameter int CARRIER_HALF   = 1389,
  parameter int START_BURST    = 191,
  parameter int SEL_BURST      = 47,
  parameter int GAP            = 25,
  parameter int ASSERT_BURST   = 47,
  parameter int DEASSERT_BURST = 22
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] COMMAND,
  input  logic       SEND_PACKET,
  output logic       IR_LED,
  output logic       BUSY
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter widths never shrink below the sizes needed by the default build,
  // and grow automatically if a larger parameter is ever used.
  localparam int LONGEST_BURST = max_of(max_of(max_of(START_BURST, SEL_BURST), GAP),
                                        max_of(ASSERT_BURST, DEASSERT_BURST));
  localparam int CW = max_of(12, $clog2(2 * CARRIER_HALF));
  localparam int PW = max_of(8, $clog2(LONGEST_BURST + 1));

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] START   = 4'd1;
  localparam logic [3:0] GAP_S   = 4'd2;
  localparam logic [3:0] SEL     = 4'd3;
  localparam logic [3:0] GAP_SEL = 4'd4;
  localparam logic [3:0] RIGHT   = 4'd5;
  localparam logic [3:0] GAP_R   = 4'd6;
  localparam logic [3:0] LEFT    = 4'd7;
  localparam logic [3:0] GAP_L   = 4'd8;
  localparam logic [3:0] BACK    = 4'd9;
  localparam logic [3:0] GAP_B   = 4'd10;
  localparam logic [3:0] FWD     = 4'd11;
  localparam logic [3:0] GAP_F   = 4'd12;

  logic [3:0]    state;
  logic [3:0]    next_field;
  logic [3:0]    cmd_latched;
  logic [CW-1:0] carrier_cnt;
  logic [PW-1:0] period_cnt;
  logic [PW-1:0] state_len;
  logic          carrier_wrap;
  logic          last_period;
  logic          in_burst;

  // Fixed field order of a packet; the final gap returns to idle.
  always_comb begin
    next_field = IDLE;
    case (state)
      START:   next_field = GAP_S;
      GAP_S:   next_field = SEL;
      SEL:     next_field = GAP_SEL;
      GAP_SEL: next_field = RIGHT;
      RIGHT:   next_field = GAP_R;
      GAP_R:   next_field = LEFT;
      LEFT:    next_field = GAP_L;
      GAP_L:   next_field = BACK;
      BACK:    next_field = GAP_B;
      GAP_B:   next_field = FWD;
      FWD:     next_field = GAP_F;
      GAP_F:   next_field = IDLE;
      default: next_field = IDLE;
    endcase
  end

  // Length of the current field in carrier periods; command fields use the
  // bit captured at request time so a changing COMMAND cannot disturb a packet.
  always_comb begin
    state_len = PW'(GAP);
    case (state)
      START:   state_len = PW'(START_BURST);
      SEL:     state_len = PW'(SEL_BURST);
      RIGHT:   state_len = cmd_latched[0] ? PW'(ASSERT_BURST) : PW'(DEASSERT_BURST);
      LEFT:    state_len = cmd_latched[1] ? PW'(ASSERT_BURST) : PW'(DEASSERT_BURST);
      BACK:    state_len = cmd_latched[2] ? PW'(ASSERT_BURST) : PW'(DEASSERT_BURST);
      FWD:     state_len = cmd_latched[3] ? PW'(ASSERT_BURST) : PW'(DEASSERT_BURST);
      default: state_len = PW'(GAP);
    endcase
  end

  // Burst fields carry the modulated carrier; gaps and idle keep the LED dark.
  always_comb begin
    in_burst = 1'b0;
    case (state)
      START, SEL, RIGHT, LEFT, BACK, FWD: in_burst = 1'b1;
      default:                            in_burst = 1'b0;
    endcase
  end

  assign carrier_wrap = (carrier_cnt == CW'(2 * CARRIER_HALF - 1));
  assign last_period  = (period_cnt == state_len - PW'(1));

  // Sequencer: accept a request only in idle, then step through the fields,
  // counting carrier periods and advancing on the edge ending the last period.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= IDLE;
      cmd_latched <= 4'b0000;
      carrier_cnt <= '0;
      period_cnt  <= '0;
    end else if (state == IDLE) begin
      carrier_cnt <= '0;
      period_cnt  <= '0;
      if (SEND_PACKET) begin
        cmd_latched <= COMMAND;
        state       <= START;
      end
    end else begin
      if (carrier_wrap) begin
        carrier_cnt <= '0;
        if (last_period) begin
          state      <= next_field;
          period_cnt <= '0;
        end else begin
          period_cnt <= period_cnt + PW'(1);
        end
      end else begin
        carrier_cnt <= carrier_cnt + CW'(1);
      end
    end
  end

  // Registered outputs: LED is high for the first half of each carrier period
  // inside a burst; BUSY covers every non-idle state.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      IR_LED <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      IR_LED <= in_burst && (carrier_cnt < CW'(CARRIER_HALF));
      BUSY   <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_ir_packet_encoder.sv
// tb_ir_packet_encoder: drives packet requests into ir_packet_encoder and
// compares the BUSY window and IR_LED waveform with a segment-list model.

module tb_ir_packet_encoder;

  localparam int T_HALF     = 2;
  localparam int T_START    = 3;
  localparam int T_SEL      = 2;
  localparam int T_GAP      = 1;
  localparam int T_ASSERT   = 2;
  localparam int T_DEASSERT = 1;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       IR_LED;
  logic       BUSY;

  int checks_total;
  int checks_passed;

  bit exp_led[$];
  bit obs_led[$];
  int obs_len;
  logic obs_tail_led;

  ir_packet_encoder #(
    .CARRIER_HALF  (T_HALF),
    .START_BURST   (T_START),
    .SEL_BURST     (T_SEL),
    .GAP           (T_GAP),
    .ASSERT_BURST  (T_ASSERT),
    .DEASSERT_BURST(T_DEASSERT)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .COMMAND    (COMMAND),
    .SEND_PACKET(SEND_PACKET),
    .IR_LED     (IR_LED),
    .BUSY       (BUSY)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int field_len(input bit b);
    return b ? T_ASSERT : T_DEASSERT;
  endfunction

  // Model: a packet is twelve alternating burst/gap segments; each period of
  // a burst is HALF cycles lit then HALF cycles dark.
  task automatic build_expected(input logic [3:0] cmd);
    int seg[12];
    seg = '{T_START, T_GAP, T_SEL, T_GAP,
            field_len(cmd[0]), T_GAP, field_len(cmd[1]), T_GAP,
            field_len(cmd[2]), T_GAP, field_len(cmd[3]), T_GAP};
    exp_led.delete();
    for (int s = 0; s < 12; s++)
      for (int p = 0; p < seg[s]; p++)
        for (int c = 0; c < 2 * T_HALF; c++)
          exp_led.push_back(((s % 2) == 0) && (c < T_HALF));
  endtask

  function automatic int first_led_mismatch();
    int n;
    n = (obs_led.size() > exp_led.size()) ? obs_led.size() : exp_led.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs_led.size() || i >= exp_led.size()) return i;
      if (obs_led[i] !== exp_led[i]) return i;
    end
    return -1;
  endfunction

  // Requests a packet and records IR_LED for every cycle BUSY is high.
  // Optional mid-packet events fire after the given sample index.
  task automatic run_packet(input logic [3:0] cmd, input int change_at,
                            input logic [3:0] change_cmd, input int send_at);
    COMMAND = cmd;
    SEND_PACKET = 1'b1;
    tick();
    SEND_PACKET = 1'b0;
    obs_led.delete();
    obs_len = 0;
    obs_tail_led = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (BUSY !== 1'b1) begin
        obs_tail_led = IR_LED;
        break;
      end
      obs_led.push_back(IR_LED);
      obs_len++;
      if (i == change_at) COMMAND = change_cmd;
      SEND_PACKET = (i == send_at);
    end
    SEND_PACKET = 1'b0;
  endtask

  task automatic idle_activity(input int n, output int active);
    active = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (BUSY !== 1'b0 || IR_LED !== 1'b0) active++;
    end
  endtask

  // Reset holds everything dark even with a request pending, and the block
  // stays idle afterwards without a new request.
  task automatic test_reset();
    int active;
    RESET_N = 1'b0;
    COMMAND = 4'hF;
    SEND_PACKET = 1'b1;
    repeat (3) tick();
    checks_total++;
    if (BUSY !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", BUSY);
    else checks_passed++;
    checks_total++;
    if (IR_LED !== 1'b0) $display("[TB] FAIL reset_led: got %b, expected 0", IR_LED);
    else checks_passed++;
    RESET_N = 1'b1;
    SEND_PACKET = 1'b0;
    idle_activity(10, active);
    checks_total++;
    if (active !== 0) $display("[TB] FAIL reset_idle: active cycles %0d, expected 0", active);
    else checks_passed++;
  endtask

  task automatic test_basic_0101();
    int mis, active;
    run_packet(4'b0101, -1, 4'b0000, -1);
    build_expected(4'b0101);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 68) $display("[TB] FAIL basic_len: got %0d, expected 68", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL basic_led: first bad cycle %0d, expected none", mis);
    else checks_passed++;
    checks_total++;
    if (obs_tail_led !== 1'b0) $display("[TB] FAIL basic_tail_led: got %b, expected 0", obs_tail_led);
    else checks_passed++;
    idle_activity(5, active);
    checks_total++;
    if (active !== 0) $display("[TB] FAIL basic_idle: active cycles %0d, expected 0", active);
    else checks_passed++;
  endtask

  task automatic test_all_zero();
    int mis;
    run_packet(4'b0000, -1, 4'b0000, -1);
    build_expected(4'b0000);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 60) $display("[TB] FAIL zero_len: got %0d, expected 60", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL zero_led: first bad cycle %0d, expected none", mis);
    else checks_passed++;
  endtask

  // COMMAND moves mid-packet; the packet keeps its captured value and the
  // next packet picks up the new one.
  task automatic test_command_change();
    int mis;
    run_packet(4'b0000, 10, 4'b1111, -1);
    build_expected(4'b0000);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 60) $display("[TB] FAIL change_len: got %0d, expected 60", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL change_led: first bad cycle %0d, expected none", mis);
    else checks_passed++;
    tick();
    run_packet(4'b1111, -1, 4'b0000, -1);
    build_expected(4'b1111);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 76) $display("[TB] FAIL next_len: got %0d, expected 76", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL next_led: first bad cycle %0d, expected none", mis);
    else checks_passed++;
  endtask

  task automatic test_ignore_send();
    int mis, active;
    tick();
    run_packet(4'b0101, -1, 4'b0000, 20);
    build_expected(4'b0101);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 68) $display("[TB] FAIL ignore_len: got %0d, expected 68", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL ignore_led: first bad cycle %0d, expected none", mis);
    else checks_passed++;
    idle_activity(10, active);
    checks_total++;
    if (active !== 0) $display("[TB] FAIL ignore_idle: active cycles %0d, expected 0", active);
    else checks_passed++;
  endtask

  // Request lands on the edge that leaves the last gap: it must be dropped.
  task automatic test_coincident();
    int active;
    run_packet(4'b0101, -1, 4'b0000, 66);
    checks_total++;
    if (obs_len !== 68) $display("[TB] FAIL coinc_len: got %0d, expected 68", obs_len);
    else checks_passed++;
    idle_activity(10, active);
    checks_total++;
    if (active !== 0) $display("[TB] FAIL coinc_idle: active cycles %0d, expected 0", active);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    int mis, active;
    COMMAND = 4'b0101;
    SEND_PACKET = 1'b1;
    tick();
    SEND_PACKET = 1'b0;
    repeat (31) tick();
    checks_total++;
    if (BUSY !== 1'b1) $display("[TB] FAIL rmid_busy_before: got %b, expected 1", BUSY);
    else checks_passed++;
    RESET_N = 1'b0;
    tick();
    checks_total++;
    if (BUSY !== 1'b0) $display("[TB] FAIL rmid_busy: got %b, expected 0", BUSY);
    else checks_passed++;
    checks_total++;
    if (IR_LED !== 1'b0) $display("[TB] FAIL rmid_led: got %b, expected 0", IR_LED);
    else checks_passed++;
    RESET_N = 1'b1;
    idle_activity(5, active);
    checks_total++;
    if (active !== 0) $display("[TB] FAIL rmid_idle: active cycles %0d, expected 0", active);
    else checks_passed++;
    run_packet(4'b0101, -1, 4'b0000, -1);
    build_expected(4'b0101);
    mis = first_led_mismatch();
    checks_total++;
    if (obs_len !== 68) $display("[TB] FAIL rmid_len: got %0d, expected 68", obs_len);
    else checks_passed++;
    checks_total++;
    if (mis !== -1) $display("[TB] FAIL rmid_led_pattern: first bad cycle %0d, expected none", mis);
    else checks_passed++;
  endtask

  // Random commands with random mid-packet COMMAND changes and stray requests.
  task automatic test_random();
    int mis, active, chg_at, snd_at;
    logic [3:0] cmd, chg;
    for (int k = 0; k < 10; k++) begin
      cmd    = 4'($urandom_range(0, 15));
      chg    = 4'($urandom_range(0, 15));
      chg_at = $urandom_range(0, 40);
      snd_at = $urandom_range(0, 55);
      run_packet(cmd, chg_at, chg, snd_at);
      build_expected(cmd);
      mis = first_led_mismatch();
      checks_total++;
      if (obs_len !== exp_led.size())
        $display("[TB] FAIL rand_len cmd=%b: got %0d, expected %0d", cmd, obs_len, exp_led.size());
      else checks_passed++;
      checks_total++;
      if (mis !== -1) $display("[TB] FAIL rand_led cmd=%b: first bad cycle %0d, expected none", cmd, mis);
      else checks_passed++;
      idle_activity($urandom_range(1, 5), active);
      checks_total++;
      if (active !== 0) $display("[TB] FAIL rand_idle cmd=%b: active cycles %0d, expected 0", cmd, active);
      else checks_passed++;
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    RESET_N       = 1'b0;
    COMMAND       = 4'b0000;
    SEND_PACKET   = 1'b0;
    test_reset();
    test_basic_0101();
    test_all_zero();
    test_command_change();
    test_ignore_send();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
